// File: rtl/seg_scan_if.sv
// Bundle between the display formatter and the digit scanner: pattern/mask
// inputs and the board-facing AN/segment/DP/frame outputs.
interface seg_scan_if #(
  parameter int NUM_DIGITS = 8
);
  logic                    enable;
  logic [7*NUM_DIGITS-1:0] seg_in;
  logic [NUM_DIGITS-1:0]   dp_in;
  logic [NUM_DIGITS-1:0]   blank_mask;
  logic [NUM_DIGITS-1:0]   blink_mask;
  logic [NUM_DIGITS-1:0]   AN;
  logic [6:0]              display;
  logic                    DP;
  logic                    frame_done;

  modport master (
    output enable, seg_in, dp_in, blank_mask, blink_mask,
    input  AN, display, DP, frame_done
  );

  modport slave (
    input  enable, seg_in, dp_in, blank_mask, blink_mask,
    output AN, display, DP, frame_done
  );
endinterface

// File: rtl/seg_scan_controller.sv
// Time-multiplexed common-anode seven-segment scanner with its own refresh
// prescaler, per-digit blank/blink, decimal-point mask and frame-done pulse.
module seg_scan_controller #(
  parameter int NUM_DIGITS   = 8,
  parameter int CLK_DIV      = 100000,
  parameter int BLINK_FRAMES = 64
) (
  input  logic      clk,
  input  logic      reset,
  seg_scan_if.slave bus
);

  localparam int P_W   = ($clog2(CLK_DIV) < 1) ? 1 : $clog2(CLK_DIV);
  localparam int IDX_W = ($clog2(NUM_DIGITS) < 1) ? 1 : $clog2(NUM_DIGITS);
  localparam int F_W   = ($clog2(BLINK_FRAMES) < 1) ? 1 : $clog2(BLINK_FRAMES);

  localparam logic [P_W-1:0]   P_LAST   = P_W'(CLK_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
  localparam logic [F_W-1:0]   F_LAST   = F_W'(BLINK_FRAMES - 1);

  logic [P_W-1:0]        p;
  logic [IDX_W-1:0]      idx;
  logic [F_W-1:0]        f;
  logic                  blink_phase;

  logic                  tick;
  logic                  wrap;
  logic                  blanked;
  logic                  go_dark;
  logic [NUM_DIGITS-1:0] an_lit;
  logic [6:0]            seg_sel;

  // Stage 0: window decode and selection of the digit currently being scanned
  always_comb begin
    tick        = bus.enable && (p == P_LAST);
    wrap        = tick && (idx == IDX_LAST);
    blanked     = bus.blank_mask[idx] || (bus.blink_mask[idx] && blink_phase);
    go_dark     = !bus.enable || tick || blanked;
    seg_sel     = bus.seg_in[7*int'(idx) +: 7];
    an_lit      = '1;
    an_lit[idx] = 1'b0;
  end

  // Stage 1: counters and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      p              <= '0;
      idx            <= '0;
      f              <= '0;
      blink_phase    <= 1'b0;
      bus.AN         <= '1;
      bus.display    <= 7'h7F;
      bus.DP         <= 1'b1;
      bus.frame_done <= 1'b0;
    end else begin
      bus.frame_done <= wrap;

      if (tick) begin
        p   <= '0;
        idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
      end else if (bus.enable) begin
        p <= p + 1'b1;
      end

      if (wrap) begin
        if (f == F_LAST) begin
          f           <= '0;
          blink_phase <= ~blink_phase;
        end else begin
          f <= f + 1'b1;
        end
      end

      // The dark cycle on tick keeps the old digit's segments off the next anode
      if (go_dark) begin
        bus.AN      <= '1;
        bus.display <= 7'h7F;
        bus.DP      <= 1'b1;
      end else begin
        bus.AN      <= an_lit;
        bus.display <= seg_sel;
        bus.DP      <= ~bus.dp_in[idx];
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_controller.sv
// Scoreboard bench for seg_scan_controller: a timeline model of the scan
// predicts every output cycle; a monitor on the falling edge compares.
module tb_seg_scan_controller;

  localparam int N = 8;
  localparam int C = 4;
  localparam int B = 2;

  typedef struct packed {
    logic [N-1:0] an;
    logic [6:0]   disp;
    logic         dp;
    logic         fd;
  } exp_t;

  logic clk = 1'b0;
  logic reset;

  seg_scan_if #(.NUM_DIGITS(N)) bus ();

  seg_scan_controller #(
    .NUM_DIGITS  (N),
    .CLK_DIV     (C),
    .BLINK_FRAMES(B)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  int   t        = 0;   // enabled cycles elapsed since the last reset

  // Outputs after the next edge, derived from the position on the scan timeline
  function automatic exp_t model(input logic rst_i, input logic en, input int tt,
                                 input logic [7*N-1:0] seg, input logic [N-1:0] dp,
                                 input logic [N-1:0] blank, input logic [N-1:0] blink);
    exp_t e;
    int pos, w, d, fr, ph;
    e.an = '1; e.disp = 7'h7F; e.dp = 1'b1; e.fd = 1'b0;
    if (rst_i || !en) return e;
    pos = tt % C;
    w   = tt / C;
    d   = w % N;
    fr  = w / N;
    ph  = (fr / B) % 2;
    if (pos == C - 1) begin
      e.fd = (d == N - 1);
      return e;
    end
    if (blank[d] || (blink[d] && ph == 1)) return e;
    e.an    = '1;
    e.an[d] = 1'b0;
    e.disp  = seg[7*d +: 7];
    e.dp    = ~dp[d];
    return e;
  endfunction

  task automatic step();
    sb.push_back(model(reset, bus.enable, t, bus.seg_in, bus.dp_in,
                       bus.blank_mask, bus.blink_mask));
    @(posedge clk);
    if (reset) t = 0;
    else if (bus.enable) t++;
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Advance until the model says the given digit is in its second window cycle
  task automatic seek_digit(input int d);
    int guard;
    guard = 0;
    while (!(((t / C) % N) == d && (t % C) == 1) && guard < 200) begin
      step();
      guard++;
    end
    checks++;
    if (guard >= 200) begin
      failures++;
      $display("FAIL seek_digit%0d timeout after %0d cycles", d, guard);
    end
  endtask

  always @(negedge clk) begin
    exp_t e, a;
    cyc++;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      a = {bus.AN, bus.display, bus.DP, bus.frame_done};
      checks++;
      if (a !== e) begin
        failures++;
        $display("FAIL outputs cyc=%0d AN=%h/%h display=%h/%h DP=%b/%b frame_done=%b/%b (got/expected)",
                 cyc, a.an, e.an, a.disp, e.disp, a.dp, e.dp, a.fd, e.fd);
      end
      checks++;
      if ($countones(~bus.AN) > 1) begin
        failures++;
        $display("FAIL one_hot_an cyc=%0d AN=%h expected at most one low bit", cyc, bus.AN);
      end
    end
  end

  initial begin
    reset          = 1'b1;
    bus.enable     = 1'b0;
    bus.dp_in      = '0;
    bus.blank_mask = '0;
    bus.blink_mask = '0;
    for (int k = 0; k < N; k++) bus.seg_in[7*k +: 7] = 7'(8'h40 + k);

    run(3);
    reset      = 1'b0;
    bus.enable = 1'b1;
    run(2 * N * C);

    // Blink on digit 0, digit 7 blanked, DP on digit 2, mid-window pattern change
    bus.blink_mask = 8'h01;
    bus.blank_mask = 8'h80;
    bus.dp_in      = 8'h04;
    seek_digit(2);
    bus.seg_in[14 +: 7] = 7'h12;
    run(5 * N * C);

    bus.blink_mask = '0;
    bus.blank_mask = '0;
    seek_digit(3);
    bus.enable = 1'b0;
    run(5);
    bus.enable = 1'b1;
    run(2 * N * C);

    seek_digit(5);
    reset = 1'b1;
    step();
    reset          = 1'b0;
    bus.blink_mask = 8'h01;
    run(3 * N * C);

    for (int i = 0; i < 600; i++) begin
      for (int k = 0; k < N; k++)
        if ($urandom_range(0, 7) == 0) bus.seg_in[7*k +: 7] = 7'($urandom);
      if ($urandom_range(0, 15) == 0) bus.dp_in      = N'($urandom);
      if ($urandom_range(0, 31) == 0) bus.blank_mask = N'($urandom) & N'($urandom);
      if ($urandom_range(0, 31) == 0) bus.blink_mask = N'($urandom);
      bus.enable = ($urandom_range(0, 9) != 0);
      reset      = ($urandom_range(0, 199) == 0);
      step();
    end
    reset = 1'b0;

    @(negedge clk);
    @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain left=%0d expected 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
